// File: rtl/fifo_write_arbiter_if.sv
// Requester-side and FIFO-side signals of the write-port arbiter, bundled as one port.
// The master modport drives requests and the full flag; the slave modport is the arbiter.
interface fifo_write_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8
);
    logic [NUM_REQ-1:0]           req;
    logic [NUM_REQ*DATA_SIZE-1:0] req_data;
    logic [NUM_REQ-1:0]           req_last;
    logic [NUM_REQ-1:0]           req_ack;
    logic                         full;
    logic                         write_inc;
    logic [DATA_SIZE-1:0]         write_data;
    logic [NUM_REQ-1:0]           grant;
    logic                         busy;

    modport master (
        output req, req_data, req_last, full,
        input  req_ack, write_inc, write_data, grant, busy
    );

    modport slave (
        input  req, req_data, req_last, full,
        output req_ack, write_inc, write_data, grant, busy
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin owner of the async FIFO write port: one grant per burst, one idle cycle between bursts.
// First beat can be pushed one cycle after req rises; full stalls the owner without releasing it.
module fifo_write_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_SIZE = 8,
    parameter int MAX_BURST = 8
) (
    input  logic                 write_clk,
    input  logic                 write_reset,
    fifo_write_arbiter_if.slave  bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_e;

    state_e               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 busy_q, busy_d;
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [7:0]           beat_cnt_q, beat_cnt_d;

    logic [DATA_SIZE-1:0] slice [NUM_REQ];
    logic [PTR_W-1:0]     pick;
    logic                 accept;
    logic                 rel;
    logic [NUM_REQ-1:0]   ack;
    logic [DATA_SIZE-1:0] wdata;

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_slice
        assign slice[i] = bus.req_data[i*DATA_SIZE +: DATA_SIZE];
    end

    // First requester at or after the round-robin pointer, wrapping at NUM_REQ-1.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                 input logic [PTR_W-1:0]   start);
        logic [PTR_W-1:0] idx;
        logic [PTR_W-1:0] sel;
        logic             found;
        idx   = start;
        sel   = start;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && r[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = (idx == PTR_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
        end
        return sel;
    endfunction

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        rr_ptr_d   = rr_ptr_q;
        owner_d    = owner_q;
        beat_cnt_d = beat_cnt_q;
        accept     = 1'b0;
        rel        = 1'b0;
        ack        = '0;
        wdata      = '0;
        pick       = rr_pick(bus.req, rr_ptr_q);

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    owner_d       = pick;
                    beat_cnt_d    = '0;
                    busy_d        = 1'b1;
                    state_d       = GRANT;
                end
            end

            GRANT: begin
                wdata        = slice[owner_q];
                accept       = bus.req[owner_q] & ~bus.full;
                ack[owner_q] = accept;
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                end
                // An owner dropping req gives the port back even mid-burst; full alone never does.
                rel = (accept & (bus.req_last[owner_q] |
                                 (beat_cnt_q == 8'(MAX_BURST - 1)))) |
                      ~bus.req[owner_q];
                if (rel) begin
                    state_d    = IDLE;
                    grant_d    = '0;
                    busy_d     = 1'b0;
                    beat_cnt_d = '0;
                    rr_ptr_d   = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (write_reset) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign bus.req_ack    = ack;
    assign bus.write_inc  = accept;
    assign bus.write_data = wdata;
    assign bus.grant      = grant_q;
    assign bus.busy       = busy_q;

    a_grant_onehot0: assert property (@(posedge write_clk) disable iff (write_reset)
        $onehot0(grant_q));
    a_inc_busy: assert property (@(posedge write_clk) disable iff (write_reset)
        bus.write_inc |-> busy_q);
    a_ack_onehot0: assert property (@(posedge write_clk) disable iff (write_reset)
        $onehot0(ack));
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Randomized bench for fifo_write_arbiter: per-requester word scoreboards plus a rule-level owner model.
module tb_fifo_write_arbiter;
    localparam int NR   = 4;
    localparam int DS   = 8;
    localparam int MAXB = 8;

    typedef struct packed {
        logic [DS-1:0] data;
        logic          last;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_write_arbiter_if #(.NUM_REQ(NR), .DATA_SIZE(DS)) bus ();

    fifo_write_arbiter #(.NUM_REQ(NR), .DATA_SIZE(DS), .MAX_BURST(MAXB)) dut (
        .write_clk   (clk),
        .write_reset (rst),
        .bus         (bus)
    );

    beat_t         src_q [NR][$];
    logic [DS-1:0] exp_q [NR][$];
    bit            pause [NR];
    int            seq   [NR];
    int            n_cmp = 0;
    int            n_err = 0;

    // Model state: who owns the port, round-robin start, beats taken in this grant.
    int            m_owner = -1;
    int            m_ptr   = 0;
    int            m_cnt   = 0;
    bit            p_rst   = 1'b1;
    bit            p_acc   = 1'b0;
    logic [NR-1:0] p_req   = '0;
    logic [NR-1:0] p_last  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic int rr_first(input logic [NR-1:0] r, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (r[(ptr + k) % NR]) return (ptr + k) % NR;
        end
        return -1;
    endfunction

    task automatic push_word(input int i, input logic [DS-1:0] d, input bit last);
        beat_t bt;
        bt.data = d;
        bt.last = last;
        src_q[i].push_back(bt);
        exp_q[i].push_back(d);
    endtask

    task automatic push_burst(input int i, input int len, input bit with_last);
        for (int b = 0; b < len; b++) begin
            push_word(i, DS'((i << 5) | (seq[i] & 31)), with_last && (b == len - 1));
            seq[i]++;
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic int pending();
        int s;
        s = 0;
        for (int i = 0; i < NR; i++) s += src_q[i].size();
        return s;
    endfunction

    task automatic wait_drain(input int budget);
        int c;
        c = 0;
        while ((pending() > 0 || bus.busy) && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) fail_now("drain_timeout");
        tick(2);
    endtask

    task automatic wait_size(input int i, input int n, input int budget);
        int c;
        c = 0;
        while (src_q[i].size() > n && c < budget) begin
            tick();
            c++;
        end
        if (c >= budget) fail_now("wait_size_timeout");
    endtask

    // Requester driver: present the head beat of each queue unless paused.
    initial begin
        bus.req      = '0;
        bus.req_data = '0;
        bus.req_last = '0;
        forever begin
            @(posedge clk);
            #2;
            for (int i = 0; i < NR; i++) begin
                if (src_q[i].size() > 0 && !pause[i]) begin
                    bus.req[i]                = 1'b1;
                    bus.req_data[i*DS +: DS]  = src_q[i][0].data;
                    bus.req_last[i]           = src_q[i][0].last;
                end else begin
                    bus.req[i]                = 1'b0;
                    bus.req_data[i*DS +: DS]  = DS'($urandom);
                    bus.req_last[i]           = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NR; i++) begin
            if (bus.req_ack[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
    end

    // Monitor: advance the owner model from last cycle's inputs, then compare outputs.
    always @(negedge clk) begin
        logic [NR-1:0] exp_grant;
        logic [NR-1:0] exp_ack;
        bit            exp_inc;
        if (p_rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_cnt   = 0;
        end else if (m_owner < 0) begin
            if (p_req != '0) begin
                m_owner = rr_first(p_req, m_ptr);
                m_cnt   = 0;
            end
        end else begin
            if (p_acc) m_cnt++;
            if ((p_acc && (p_last[m_owner] || m_cnt == MAXB)) || !p_req[m_owner]) begin
                m_ptr   = (m_owner + 1) % NR;
                m_owner = -1;
            end
        end

        exp_grant = '0;
        exp_ack   = '0;
        exp_inc   = 1'b0;
        if (m_owner >= 0) begin
            exp_grant[m_owner] = 1'b1;
            exp_inc = bus.req[m_owner] && !bus.full;
            if (exp_inc) exp_ack[m_owner] = 1'b1;
        end
        check("grant", 32'(bus.grant), 32'(exp_grant));
        check("busy", 32'(bus.busy), 32'(m_owner >= 0));
        check("write_inc", 32'(bus.write_inc), 32'(exp_inc));
        check("req_ack", 32'(bus.req_ack), 32'(exp_ack));
        if (m_owner < 0) begin
            check("write_data_idle", 32'(bus.write_data), 32'h0);
        end else if (exp_inc && bus.write_inc) begin
            if (exp_q[m_owner].size() == 0) fail_now("unexpected_write");
            else check("write_data", 32'(bus.write_data), 32'(exp_q[m_owner].pop_front()));
        end

        p_rst  = rst;
        p_req  = bus.req;
        p_last = bus.req_last;
        p_acc  = exp_inc;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        bus.full = 1'b0;
        for (int k = 0; k < NR; k++) begin
            pause[k] = 1'b0;
            seq[k]   = 0;
        end
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2);

        // Single requester, three beats.
        push_word(1, 8'hA1, 1'b0);
        push_word(1, 8'hA2, 1'b0);
        push_word(1, 8'hA3, 1'b1);
        wait_drain(100);

        // Fairness from a freshly reset pointer: expected order 0,1,2,3,0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < NR; k++) push_burst(k, 1, 1'b1);
        push_burst(0, 1, 1'b1);
        wait_drain(100);

        // Burst cut at MAX_BURST, alone and then with requester 3 waiting.
        push_burst(2, 10, 1'b0);
        wait_drain(100);
        push_burst(2, 10, 1'b0);
        push_burst(3, 2, 1'b1);
        wait_drain(100);

        // Full stall in the middle of a burst.
        push_burst(0, 6, 1'b1);
        tick(3);
        bus.full = 1'b1;
        tick(4);
        bus.full = 1'b0;
        wait_drain(100);

        // Owner abandons after two beats, then resumes later.
        push_burst(1, 4, 1'b1);
        wait_size(1, 2, 50);
        pause[1] = 1'b1;
        tick(3);
        pause[1] = 1'b0;
        wait_drain(100);

        // Reset during beat 2, then requester 3.
        push_burst(0, 4, 1'b1);
        wait_size(0, 3, 50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_burst(3, 2, 1'b1);
        wait_drain(100);

        // Random traffic with full, pauses and rare resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            i = $urandom_range(0, NR - 1);
            if (src_q[i].size() < 4 && $urandom_range(0, 3) == 0)
                push_burst(i, $urandom_range(1, 12), $urandom_range(0, 4) != 0);
            bus.full = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 40) == 0) begin
                i = $urandom_range(0, NR - 1);
                pause[i] = !pause[i];
            end
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst      = 1'b0;
        bus.full = 1'b0;
        for (int k = 0; k < NR; k++) pause[k] = 1'b0;
        wait_drain(3000);

        for (int k = 0; k < NR; k++) check("leftover_words", 32'(exp_q[k].size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
